// File: rtl/core_pkg.sv
// Shared core types: LSU operation codes, LSU state encoding
// and the size/alignment helpers used by the load/store path.
package core_pkg;

    typedef enum logic [2:0] {
        LSU_LB,
        LSU_LH,
        LSU_LW,
        LSU_LBU,
        LSU_LHU,
        LSU_SB,
        LSU_SH,
        LSU_SW
    } load_store_func_code;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RV
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } lsu_size_e;

    function automatic lsu_size_e op_size(load_store_func_code op);
        lsu_size_e sz;
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: sz = SZ_BYTE;
            LSU_LH, LSU_LHU, LSU_SH: sz = SZ_HALF;
            default:                 sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_store(load_store_func_code op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    function automatic logic is_aligned(load_store_func_code op, logic [1:0] a);
        logic ok;
        case (op_size(op))
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~a[0];
            default: ok = (a == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables, store-lane replication
// and load extraction with sign/zero extension.
module lsu_align
    import core_pkg::*;
(
    input  load_store_func_code op,
    input  logic [1:0]          addr,
    input  logic [31:0]         wdata,
    input  logic [31:0]         rdata,
    output logic [3:0]          be,
    output logic [31:0]         wdata_lane,
    output logic [31:0]         rdata_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        unique case (op_size(op))
            SZ_BYTE: begin
                be         = 4'b0001 << addr;
                wdata_lane = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be         = addr[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
            end
            default: begin
                be         = 4'b1111;
                wdata_lane = wdata;
            end
        endcase
    end

    always_comb begin
        rbyte = rdata[7:0];
        unique case (addr)
            2'd0:    rbyte = rdata[7:0];
            2'd1:    rbyte = rdata[15:8];
            2'd2:    rbyte = rdata[23:16];
            default: rbyte = rdata[31:24];
        endcase
        rhalf = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        rdata_ext = rdata;
        case (op)
            LSU_LB:  rdata_ext = {{24{rbyte[7]}}, rbyte};
            LSU_LBU: rdata_ext = {24'h0, rbyte};
            LSU_LH:  rdata_ext = {{16{rhalf[15]}}, rhalf};
            LSU_LHU: rdata_ext = {16'h0, rhalf};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding request, req/gnt then
// rvalid handshake, misalignment and timeout error pulses.
module load_store_unit
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_lsu_ip,
    input  load_store_func_code lsu_operator_ip,
    input  logic [31:0]         addr_ip,
    input  logic                addr_valid_ip,
    input  logic [31:0]         wdata_ip,
    output logic                data_req_op,
    output logic [31:0]         data_addr_op,
    output logic                data_we_op,
    output logic [3:0]          data_be_op,
    output logic [31:0]         data_wdata_op,
    input  logic                data_gnt_ip,
    input  logic                data_rvalid_ip,
    input  logic [31:0]         data_rdata_ip,
    output logic [31:0]         mem_data_op,
    output logic                mem_data_valid_op,
    output logic                busy_op,
    output logic                err_op
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_e          state;
    load_store_func_code op_q;
    logic [1:0]          addr_lo_q;
    logic [CW-1:0]       cnt;

    load_store_func_code op_sel;
    logic [1:0]          addr_sel;
    logic [3:0]          be;
    logic [31:0]         wdata_lane;
    logic [31:0]         rdata_ext;
    logic                timeout;

    // IDLE steers the live request; otherwise the latched load op.
    assign op_sel   = (state == IDLE) ? lsu_operator_ip : op_q;
    assign addr_sel = (state == IDLE) ? addr_ip[1:0] : addr_lo_q;
    assign timeout  = (cnt == CNT_LAST);
    assign busy_op  = (state != IDLE);

    lsu_align u_align (
        .op         (op_sel),
        .addr       (addr_sel),
        .wdata      (wdata_ip),
        .rdata      (data_rdata_ip),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            op_q              <= LSU_LB;
            addr_lo_q         <= 2'b00;
            cnt               <= '0;
            data_req_op       <= 1'b0;
            data_addr_op      <= 32'h0;
            data_we_op        <= 1'b0;
            data_be_op        <= 4'h0;
            data_wdata_op     <= 32'h0;
            mem_data_op       <= 32'h0;
            mem_data_valid_op <= 1'b0;
            err_op            <= 1'b0;
        end else begin
            err_op            <= 1'b0;
            mem_data_valid_op <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en_lsu_ip && addr_valid_ip) begin
                        if (is_aligned(lsu_operator_ip, addr_ip[1:0])) begin
                            state         <= REQ;
                            op_q          <= lsu_operator_ip;
                            addr_lo_q     <= addr_ip[1:0];
                            cnt           <= '0;
                            data_req_op   <= 1'b1;
                            data_addr_op  <= {addr_ip[31:2], 2'b00};
                            data_we_op    <= is_store(lsu_operator_ip);
                            data_be_op    <= be;
                            data_wdata_op <= wdata_lane;
                        end else begin
                            err_op <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (data_gnt_ip) begin
                        data_req_op <= 1'b0;
                        state       <= data_we_op ? IDLE : WAIT_RV;
                        cnt         <= cnt + 1'b1;
                    end else if (timeout) begin
                        data_req_op <= 1'b0;
                        err_op      <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_RV: begin
                    if (data_rvalid_ip) begin
                        mem_data_op       <= rdata_ext;
                        mem_data_valid_op <= 1'b1;
                        state             <= IDLE;
                    end else if (timeout) begin
                        err_op <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, SHALL set the max cycles spent in REQ+WAIT_RV before abort.
REQ-002 clock  in  1  sole clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 en_lsu_ip  in  1  decode requests a memory op.
REQ-005 lsu_operator_ip  in  load_store_func_code  LB/LH/LW/LBU/LHU/SB/SH/SW.
REQ-006 addr_ip  in  32  effective byte address (ALU result).
REQ-007 addr_valid_ip  in  1  addr_ip valid.
REQ-008 wdata_ip  in  32  store data (rs2), low bits significant for SB/SH.
REQ-009 data_req_op  out  1  memory request.
REQ-010 data_addr_op  out  32  word address, bits[1:0]=0.
REQ-011 data_we_op  out  1  1=store, 0=load.
REQ-012 data_be_op  out  4  byte enables.
REQ-013 data_wdata_op  out  32  lane-aligned store data.
REQ-014 data_gnt_ip  in  1  memory accepts request.
REQ-015 data_rvalid_ip  in  1  load data valid.
REQ-016 data_rdata_ip  in  32  raw load word.
REQ-017 mem_data_op  out  32  extended load result to register-file writeback.
REQ-018 mem_data_valid_op  out  1  one-cycle pulse, mem_data_op valid.
REQ-019 busy_op  out  1  high whenever state != IDLE.
REQ-020 err_op  out  1  one-cycle pulse on misalignment or timeout.

Function
REQ-021 FSM states SHALL be IDLE, REQ, WAIT_RV.
REQ-022 IDLE: en_lsu_ip & addr_valid_ip & aligned -> latch op/addr/wdata, go REQ next cycle; otherwise stay.
REQ-023 Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0; LB/LBU/SB always aligned.
REQ-024 Misaligned request in IDLE SHALL issue no memory request, pulse err_op the next cycle, remain IDLE.
REQ-025 en_lsu_ip while busy_op=1 SHALL be ignored (no queueing).
REQ-026 REQ: data_req_op=1; addr/we/be/wdata held stable from latched values until gnt.
REQ-027 REQ + gnt: store -> IDLE; load -> WAIT_RV; data_req_op drops the following cycle.
REQ-028 WAIT_RV + rvalid: register extended result, pulse mem_data_valid_op next cycle, -> IDLE.
REQ-029 rvalid outside WAIT_RV SHALL be ignored; gnt outside REQ SHALL be ignored.
REQ-030 Min load latency: accept cycle N, req N+1 (gnt N+1), rvalid N+2, mem_data_valid_op N+3.
REQ-031 Min store latency: accept N, req+gnt N+1, IDLE N+2 (accepting again).
REQ-032 Byte enables: byte 1<<addr[1:0]; half addr[1]?1100:0011; word 1111; same for loads.
REQ-033 Store data: SB byte replicated x4; SH half replicated x2; SW unchanged.
REQ-034 Load extract: LB/LBU byte lane addr[1:0], LH/LHU half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW raw.
REQ-035 Timeout counter: clears on entering REQ, increments each cycle in REQ/WAIT_RV; at TIMEOUT_CYCLES -> IDLE, drop req, pulse err_op, no valid pulse.
REQ-036 mem_data_op SHALL hold its last value between pulses.

Reset
REQ-037 reset low SHALL immediately force IDLE, data_req_op=0, data_we_op=0, data_be_op=0, data_addr_op=0, data_wdata_op=0, mem_data_op=0, mem_data_valid_op=0, err_op=0, busy_op=0, counter=0.
REQ-038 Reset mid-transaction SHALL abandon it; a late rvalid after reset release is ignored.

Structure
REQ-039 load_store_func_code and the LSU state enum SHALL live in CORE_PKG; TIMEOUT_CYCLES stays a module parameter.
REQ-040 Combinational sub-module lsu_align SHALL compute be, store-lane data and load extraction.

Verification
REQ-041 LW addr 0x100, gnt same cycle, rvalid next, rdata 0xDEADBEEF -> data_addr 0x100, be 1111, mem_data 0xDEADBEEF, valid at N+3.
REQ-042 LB addr 0x103, rdata 0x80112233 -> be 1000, mem_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-043 SH addr 0x202, wdata 0x0000ABCD, gnt delayed 3 cycles -> req held 4 cycles, addr 0x200, be 1100, wdata 0xABCDABCD, no valid pulse.
REQ-044 LW addr 0x101 -> no data_req_op, err_op one pulse, busy_op stays 0.
REQ-045 LW, gnt given, rvalid never -> after TIMEOUT_CYCLES err_op pulse, busy_op 0, later stray rvalid ignored.
REQ-046 reset asserted while in WAIT_RV -> data_req_op/busy_op 0 immediately, no mem_data_valid_op after release.
